alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the combinational datapath ALU.
//  - Accepts one operation per valid/ready transfer and returns a registered result plus zero and error flags.
//  - Single-cycle ops complete with 1-cycle latency.
//  - Unsigned divide/remainder runs on an iterative restoring divider.
//  - Sits between the register-read stage and writeback in the core pipeline.
// PARAMETERS
//  WIDTH  32  operand/result width in bits, >=8, power of 2
//  OPW    6   opcode width
//  SHW    $clog2(WIDTH)  shift-amount bits taken from b[SHW-1:0] (derived, localparam)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      block can accept a request this cycle
//  in_op      in   OPW    opcode
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_result out  WIDTH  result
//  out_zero   out  1      out_result == 0
//  out_err    out  1      illegal opcode, or divide by zero
// BEHAVIOUR
//  Opcodes:
//   00 ADD a+b; 01 ADD4 a+4; 02 SUB a-b; 03 SLL a<<b[SHW-1:0]; 04 SRA; 05 SRL
//   06 AND; 07 OR; 08 XOR
//   09 SGT; 0A UGT; 0B SLT; 0C ULT; 0D SLE; 0E ULE; 0F SGE; 10 UGE
//   11 DIVU quotient; 12 REMU remainder; all others illegal
//  - Compares return 1 or 0 zero-extended to WIDTH.
//  - Add/sub wrap modulo 2^WIDTH; no carry-out.
//  Reset: state=IDLE, out_valid=0, out_result=0, out_zero=0, out_err=0, in_ready=1.
//  Transfer rules:
//   - Input transfer = in_valid & in_ready.
//   - Output transfer = out_valid & out_ready.
//   - out_* fields hold stable while out_valid=1 and out_ready=0.
//  FSM (IDLE, DIV, HOLD):
//   IDLE: in_ready=1.
//    - Single-cycle op accepted: result registered, out_valid=1 next cycle, go HOLD.
//    - DIVU/REMU with b!=0: load divider, go DIV.
//    - DIVU/REMU with b==0: next cycle result={WIDTH{1}} (DIVU) or a (REMU), out_err=1, go HOLD.
//    - Illegal op: next cycle result=0, out_zero=1, out_err=1, go HOLD.
//   DIV: in_ready=0; one quotient bit per cycle, WIDTH cycles.
//    - Then out_valid=1, go HOLD.
//    - Latency from accept to out_valid = WIDTH+1 cycles.
//   HOLD: out_valid=1.
//    - On output transfer: go IDLE.
//    - in_ready = out_ready (bypass), so a new op is accepted in the same cycle the result drains.
//    - Back-to-back single-cycle ops therefore sustain 1 op/cycle.
//  Boundaries:
//   - Reset asserted mid-DIV aborts; no result is produced.
//   - in_valid while in_ready=0 is ignored; the source holds the request.
//   - Shift by amount >= WIDTH cannot occur because only SHW bits are used.
//   - SRA of a negative operand fills with 1s.
// CONFIGURATION
//  ALU_MUL_EN defined:
//   - Opcode 13 MULLO = low WIDTH bits of a*b (unsigned).
//   - Single-cycle, same path as the other single-cycle ops.
//  ALU_MUL_EN undefined:
//   - Opcode 13 is illegal (result 0, out_err=1).
//   - No multiplier is synthesised.
// TESTING
//  - Reset: rst_n low mid-DIV -> out_valid=0 and in_ready=1 immediately; no stale result after release.
//  - ADD 0xFFFFFFFF+1, out_ready=1 -> result 0, out_zero=1, out_valid 1 cycle after accept.
//  - Stream SUB, SLT(-1,1), SRA(0x80000000,4) back-to-back, out_ready=1 ->
//    results 1/cycle: a-b, 1, 0xF8000000.
//  - DIVU 100/7 then REMU 100/7 -> 14 after 33 cycles, then 2.
//    in_ready=0 throughout DIV.
//  - DIVU 5/0 -> 0xFFFFFFFF with out_err=1; op 0x3F -> result 0, out_zero=1, out_err=1.
//  - Hold out_ready=0 for 5 cycles after ADD -> out_* stable, in_ready=0.
//    ALU_MUL_EN: MULLO 0x10000*0x10000 -> 0.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU with 1-cycle single ops and an iterative restoring divider for DIVU/REMU.
// Optional feature: define ALU_MUL_EN to add the single-cycle MULLO opcode (0x13).
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_err
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_ADD4 = OPW'(6'h01);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'h02);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(6'h03);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(6'h04);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(6'h05);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6'h06);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6'h07);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(6'h08);
    localparam logic [OPW-1:0] OP_SGT  = OPW'(6'h09);
    localparam logic [OPW-1:0] OP_UGT  = OPW'(6'h0A);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(6'h0B);
    localparam logic [OPW-1:0] OP_ULT  = OPW'(6'h0C);
    localparam logic [OPW-1:0] OP_SLE  = OPW'(6'h0D);
    localparam logic [OPW-1:0] OP_ULE  = OPW'(6'h0E);
    localparam logic [OPW-1:0] OP_SGE  = OPW'(6'h0F);
    localparam logic [OPW-1:0] OP_UGE  = OPW'(6'h10);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(6'h11);
    localparam logic [OPW-1:0] OP_REMU = OPW'(6'h12);
`ifdef ALU_MUL_EN
    localparam logic [OPW-1:0] OP_MUL  = OPW'(6'h13);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q,   zero_d;
    logic               err_q,    err_d;
    logic               valid_q,  valid_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [WIDTH-1:0]   quo_q,    quo_d;
    logic [WIDTH-1:0]   dvsr_q,   dvsr_d;
    logic [SHW-1:0]     cnt_q,    cnt_d;
    logic               is_rem_q, is_rem_d;

    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_legal_s;
    logic [SHW-1:0]     shamt_s;
    logic               is_div_s;
    logic               in_ready_s;
    logic               accept_s;
    logic [WIDTH:0]     partial_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   rem_step_s;
    logic [WIDTH-1:0]   quo_step_s;

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    function automatic logic [WIDTH-1:0] flag_word(input logic f);
        return {{(WIDTH-1){1'b0}}, f};
    endfunction

    assign shamt_s  = in_b[SHW-1:0];
    assign is_div_s = (in_op == OP_DIVU) || (in_op == OP_REMU);
    assign accept_s = in_valid & in_ready_s;

    // Single-cycle datapath result and opcode legality
    always_comb begin
        alu_res_s   = {WIDTH{1'b0}};
        alu_legal_s = 1'b1;
        case (in_op)
            OP_ADD:  alu_res_s = in_a + in_b;
            OP_ADD4: alu_res_s = in_a + WIDTH'(3'd4);
            OP_SUB:  alu_res_s = in_a - in_b;
            OP_SLL:  alu_res_s = in_a << shamt_s;
            OP_SRA:  alu_res_s = $signed(in_a) >>> shamt_s;
            OP_SRL:  alu_res_s = in_a >> shamt_s;
            OP_AND:  alu_res_s = in_a & in_b;
            OP_OR:   alu_res_s = in_a | in_b;
            OP_XOR:  alu_res_s = in_a ^ in_b;
            OP_SGT:  alu_res_s = flag_word($signed(in_a) >  $signed(in_b));
            OP_UGT:  alu_res_s = flag_word(in_a >  in_b);
            OP_SLT:  alu_res_s = flag_word($signed(in_a) <  $signed(in_b));
            OP_ULT:  alu_res_s = flag_word(in_a <  in_b);
            OP_SLE:  alu_res_s = flag_word($signed(in_a) <= $signed(in_b));
            OP_ULE:  alu_res_s = flag_word(in_a <= in_b);
            OP_SGE:  alu_res_s = flag_word($signed(in_a) >= $signed(in_b));
            OP_UGE:  alu_res_s = flag_word(in_a >= in_b);
            // Divides never take this path; the FSM routes them to the divider.
            OP_DIVU, OP_REMU: alu_res_s = {WIDTH{1'b0}};
`ifdef ALU_MUL_EN
            OP_MUL:  alu_res_s = in_a * in_b;
`endif
            default: begin
                alu_res_s   = {WIDTH{1'b0}};
                alu_legal_s = 1'b0;
            end
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        partial_s = {rem_q, quo_q[WIDTH-1]};
        diff_s    = partial_s - {1'b0, dvsr_q};
        if (!diff_s[WIDTH]) begin
            rem_step_s = diff_s[WIDTH-1:0];
            quo_step_s = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step_s = partial_s[WIDTH-1:0];
            quo_step_s = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Input-side ready; HOLD forwards out_ready so a draining slot can refill at once
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            S_IDLE:  in_ready_s = 1'b1;
            S_DIV:   in_ready_s = 1'b0;
            S_HOLD:  in_ready_s = out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Next-state and result/divider register updates
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        valid_d  = valid_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        is_rem_d = is_rem_q;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (accept_s) begin
                    if (is_div_s) begin
                        if (is_zero(in_b)) begin
                            result_d = (in_op == OP_DIVU) ? {WIDTH{1'b1}} : in_a;
                            zero_d   = (in_op == OP_DIVU) ? 1'b0 : is_zero(in_a);
                            err_d    = 1'b1;
                            valid_d  = 1'b1;
                            state_d  = S_HOLD;
                        end else begin
                            rem_d    = {WIDTH{1'b0}};
                            quo_d    = in_a;
                            dvsr_d   = in_b;
                            cnt_d    = {SHW{1'b0}};
                            is_rem_d = (in_op == OP_REMU);
                            valid_d  = 1'b0;
                            state_d  = S_DIV;
                        end
                    end else begin
                        result_d = alu_res_s;
                        zero_d   = is_zero(alu_res_s);
                        err_d    = ~alu_legal_s;
                        valid_d  = 1'b1;
                        state_d  = S_HOLD;
                    end
                end else if ((state_q == S_HOLD) && out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            S_DIV: begin
                rem_d = rem_step_s;
                quo_d = quo_step_s;
                cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
                // The last step registers its own outcome so latency stays WIDTH+1
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    result_d = is_rem_q ? rem_step_s : quo_step_s;
                    zero_d   = is_zero(is_rem_q ? rem_step_s : quo_step_s);
                    err_d    = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = S_HOLD;
                end else begin
                    state_d  = S_DIV;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, result and divider registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            rem_q    <= {WIDTH{1'b0}};
            quo_q    <= {WIDTH{1'b0}};
            dvsr_q   <= {WIDTH{1'b0}};
            cnt_q    <= {SHW{1'b0}};
            is_rem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
            is_rem_q <= is_rem_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops against an arithmetic model.
module tb_alu_seq;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_zero;
    logic          out_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .OPW(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    function automatic void model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic z, output logic e);
        r = '0;
        e = 1'b0;
        case (op)
            6'h00: r = a + b;
            6'h01: r = a + 32'd4;
            6'h02: r = a - b;
            6'h03: r = a << b[4:0];
            6'h04: r = $signed(a) >>> b[4:0];
            6'h05: r = a >> b[4:0];
            6'h06: r = a & b;
            6'h07: r = a | b;
            6'h08: r = a ^ b;
            6'h09: r = {31'd0, $signed(a) >  $signed(b)};
            6'h0A: r = {31'd0, a >  b};
            6'h0B: r = {31'd0, $signed(a) <  $signed(b)};
            6'h0C: r = {31'd0, a <  b};
            6'h0D: r = {31'd0, $signed(a) <= $signed(b)};
            6'h0E: r = {31'd0, a <= b};
            6'h0F: r = {31'd0, $signed(a) >= $signed(b)};
            6'h10: r = {31'd0, a >= b};
            6'h11: begin if (b == 0) begin r = '1; e = 1'b1; end else r = a / b; end
            6'h12: begin if (b == 0) begin r = a;  e = 1'b1; end else r = a % b; end
`ifdef ALU_MUL_EN
            6'h13: r = a * b;
`endif
            default: begin r = '0; e = 1'b1; end
        endcase
        z = (r == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until the DUT takes it (bounded).
    task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output bit timeout);
        bit fired = 1'b0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        for (int i = 0; i < 100 && !fired; i++) begin
            #3;
            fired = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        timeout = !fired;
    endtask

    // Latency counts the accept edge as 1.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else n_pass++;
        n_total++; if (out_result !== 32'd0) $display("FAIL reset_result got %h want 0", out_result); else n_pass++;
        n_total++; if (out_zero !== 1'b0) $display("FAIL reset_zero got %0b want 0", out_zero); else n_pass++;
        n_total++; if (out_err !== 1'b0) $display("FAIL reset_err got %0b want 0", out_err); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_add_wrap();
        bit to; int lat;
        out_ready = 1'b1;
        issue(6'h00, 32'hFFFF_FFFF, 32'd1, to);
        wait_out(lat);
        n_total++; if (to || lat != 1) $display("FAIL add_latency got %0d (timeout %0b) want 1", lat, to); else n_pass++;
        n_total++; if ({out_result, out_zero, out_err} !== {32'd0, 1'b1, 1'b0})
            $display("FAIL add_wrap got %h z%0b e%0b want 0 z1 e0", out_result, out_zero, out_err); else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [5:0]   ops [3];
        logic [W-1:0] as  [3];
        logic [W-1:0] bs  [3];
        logic [W-1:0] exp_r [3];
        int ready_bad = 0;
        ops[0] = 6'h02; as[0] = $urandom; bs[0] = $urandom;
        ops[1] = 6'h0B; as[1] = 32'hFFFF_FFFF; bs[1] = 32'd1;
        ops[2] = 6'h04; as[2] = 32'h8000_0000; bs[2] = 32'd4;
        exp_r[0] = as[0] - bs[0];
        exp_r[1] = 32'd1;
        exp_r[2] = 32'hF800_0000;
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = ops[0]; in_a = as[0]; in_b = bs[0];
        for (int k = 0; k < 3; k++) begin
            #3;
            if (in_ready !== 1'b1) ready_bad++;
            @(posedge clk);
            #1;
            if (k < 2) begin in_op = ops[k+1]; in_a = as[k+1]; in_b = bs[k+1]; end
            else in_valid = 1'b0;
            n_total++; if (out_valid !== 1'b1 || out_result !== exp_r[k])
                $display("FAIL stream_%0d got v%0b %h want v1 %h", k, out_valid, out_result, exp_r[k]); else n_pass++;
        end
        n_total++; if (ready_bad != 0) $display("FAIL stream_ready got %0d stalls want 0", ready_bad); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL stream_drain got v%0b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_divide();
        bit to; int lat; int busy_bad;
        logic [5:0] ops [2];
        logic [W-1:0] exp_r [2];
        ops[0] = 6'h11; exp_r[0] = 32'd14;
        ops[1] = 6'h12; exp_r[1] = 32'd2;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            busy_bad = 0;
            issue(ops[k], 32'd100, 32'd7, to);
            lat = 1;
            while (!out_valid && lat < 200) begin
                #2;
                if (in_ready !== 1'b0) busy_bad++;
                tick();
                lat++;
            end
            n_total++; if (to || lat != W + 1) $display("FAIL div_latency_%0d got %0d want %0d", k, lat, W + 1); else n_pass++;
            n_total++; if (busy_bad != 0) $display("FAIL div_ready_%0d got %0d ready cycles want 0", k, busy_bad); else n_pass++;
            n_total++; if ({out_result, out_err} !== {exp_r[k], 1'b0})
                $display("FAIL div_result_%0d got %h e%0b want %h e0", k, out_result, out_err, exp_r[k]); else n_pass++;
            drain();
        end
    endtask

    task automatic test_errors();
        bit to; int lat;
        logic [5:0]   ops [4];
        logic [W-1:0] as  [4];
        logic [W-1:0] bs  [4];
        logic [W+1:0] exp_v [4];
        ops[0] = 6'h11; as[0] = 32'd5; bs[0] = 32'd0; exp_v[0] = {32'hFFFF_FFFF, 1'b0, 1'b1};
        ops[1] = 6'h12; as[1] = 32'd9; bs[1] = 32'd0; exp_v[1] = {32'd9, 1'b0, 1'b1};
        ops[2] = 6'h3F; as[2] = $urandom; bs[2] = $urandom; exp_v[2] = {32'd0, 1'b1, 1'b1};
        ops[3] = 6'h13; as[3] = 32'h0001_0000; bs[3] = 32'h0001_0000;
`ifdef ALU_MUL_EN
        exp_v[3] = {32'd0, 1'b1, 1'b0};
`else
        exp_v[3] = {32'd0, 1'b1, 1'b1};
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue(ops[k], as[k], bs[k], to);
            wait_out(lat);
            n_total++; if (to || lat != 1 || {out_result, out_zero, out_err} !== exp_v[k])
                $display("FAIL err_op%h got %h z%0b e%0b lat %0d want %h lat 1", ops[k], out_result, out_zero, out_err, lat, exp_v[k]);
            else n_pass++;
            drain();
        end
    endtask

    task automatic test_hold();
        bit to; int ready_bad = 0; int stable_bad = 0;
        logic [W-1:0] a1, b1, a2, b2, r1, r2;
        logic z1, e1, z2, e2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        model(6'h00, a1, b1, r1, z1, e1);
        model(6'h08, a2, b2, r2, z2, e2);
        out_ready = 1'b0;
        issue(6'h00, a1, b1, to);
        in_valid = 1'b1; in_op = 6'h08; in_a = a2; in_b = b2;
        for (int k = 0; k < 5; k++) begin
            #3;
            if (in_ready !== 1'b0) ready_bad++;
            tick();
            if ({out_valid, out_result, out_zero, out_err} !== {1'b1, r1, z1, e1}) stable_bad++;
        end
        n_total++; if (to || stable_bad != 0) $display("FAIL hold_stable got %0d bad cycles want 0", stable_bad); else n_pass++;
        n_total++; if (ready_bad != 0) $display("FAIL hold_ready got %0d ready cycles want 0", ready_bad); else n_pass++;
        out_ready = 1'b1;
        #3;
        n_total++; if (in_ready !== 1'b1) $display("FAIL hold_bypass got %0b want 1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_total++; if ({out_valid, out_result, out_zero, out_err} !== {1'b1, r2, z2, e2})
            $display("FAIL hold_next got v%0b %h want v1 %h", out_valid, out_result, r2); else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid_div();
        bit to; int stale = 0;
        out_ready = 1'b1;
        issue(6'h11, $urandom, 32'd3, to);
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_mid_div got v%0b r%0b want v0 r1", out_valid, in_ready); else n_pass++;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 2 * W; k++) begin
            tick();
            if (out_valid !== 1'b0) stale++;
        end
        n_total++; if (stale != 0) $display("FAIL rst_stale got %0d valid cycles want 0", stale); else n_pass++;
    endtask

    task automatic test_random();
        bit to; int lat;
        logic [5:0] op; logic [W-1:0] a, b, r; logic z, e;
        out_ready = 1'b1;
        for (int k = 0; k < 150; k++) begin
            op = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(21, 63)) : 6'($urandom_range(0, 19));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 40));
                2:       b = a;
                default: b = $urandom;
            endcase
            model(op, a, b, r, z, e);
            issue(op, a, b, to);
            wait_out(lat);
            n_total++; if (to || {out_result, out_zero, out_err} !== {r, z, e})
                $display("FAIL rand_%0d op%h a%h b%h got %h z%0b e%0b want %h z%0b e%0b",
                         k, op, a, b, out_result, out_zero, out_err, r, z, e);
            else n_pass++;
            drain();
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 6'h00; in_a = '0; in_b = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_add_wrap();
        test_back_to_back();
        test_divide();
        test_errors();
        test_hold();
        test_reset_mid_div();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
